// File: rtl/proppy_bytebeat_pkg.sv
// Shared definitions for the bytebeat generator: formula encodings,
// tick-rate table and the default width of the sample counter.
package proppy_bytebeat_pkg;

    localparam int T_W_DEFAULT = 24;

    typedef enum logic [2:0] {
        F_SAW = 3'd0,
        F_F1  = 3'd1,
        F_F2  = 3'd2,
        F_F3  = 3'd3,
        F_F4  = 3'd4,
        F_F5  = 3'd5,
        F_F6  = 3'd6,
        F_F7  = 3'd7
    } formula_e;

    localparam logic [15:0] RATE_DIV_0 = 16'd1;
    localparam logic [15:0] RATE_DIV_1 = 16'd16;
    localparam logic [15:0] RATE_DIV_2 = 16'd256;
    localparam logic [15:0] RATE_DIV_3 = 16'd1250;

    function automatic logic [15:0] rate_div(input logic [1:0] sel);
        logic [15:0] n;
        case (sel)
            2'd0:    n = RATE_DIV_0;
            2'd1:    n = RATE_DIV_1;
            2'd2:    n = RATE_DIV_2;
            default: n = RATE_DIV_3;
        endcase
        return n;
    endfunction

    // Low byte of a logical right shift; all formula terms only need 8 bits.
    function automatic logic [7:0] shr8(input logic [31:0] v, input int unsigned k);
        logic [31:0] s;
        s = v >> k;
        return s[7:0];
    endfunction

endpackage

// File: rtl/proppy_bytebeat_formula.sv
// Combinational bytebeat formula bank; produces the low byte of the
// selected formula for the given sample counter value.
module bytebeat_formula
    import proppy_bytebeat_pkg::*;
#(
    parameter int T_W = T_W_DEFAULT
) (
    input  logic [T_W-1:0] t,
    input  logic [2:0]     sel,
    output logic [7:0]     sample
);

    logic [31:0] t_w;
    logic [7:0]  t0;
    logic [7:0]  t3;
    logic [7:0]  t4;
    logic [7:0]  t5;
    logic [7:0]  t7;
    logic [7:0]  t8;
    logic [7:0]  t10;
    logic [7:0]  t11;
    logic [7:0]  t12;

    always_comb begin
        t_w = 32'(t);
        t0  = shr8(t_w, 0);
        t3  = shr8(t_w, 3);
        t4  = shr8(t_w, 4);
        t5  = shr8(t_w, 5);
        t7  = shr8(t_w, 7);
        t8  = shr8(t_w, 8);
        t10 = shr8(t_w, 10);
        t11 = shr8(t_w, 11);
        t12 = shr8(t_w, 12);
    end

    // Products are 8x8 truncated to 8 bits: higher bits never reach the output.
    always_comb begin
        sample = 8'd0;
        case (formula_e'(sel))
            F_SAW:   sample = t0;
            F_F1:    sample = t0 * (t5 | t8);
            F_F2:    sample = t0 * ((t12 | t8) & 8'd63 & t4);
            F_F3:    sample = ((t0 * 8'd5) & t7) | ((t0 * 8'd3) & t10);
            F_F4:    sample = t0 * (t11 & t8 & 8'd123 & t3);
            F_F5:    sample = t0 ^ t8;
            F_F6:    sample = ((t0 * 8'd9) & t4) | ((t0 * 8'd5) & t7) | ((t0 * 8'd3) & t10);
            F_F7:    sample = (t10 & 8'd42) * t0;
            default: sample = t0;
        endcase
    end

endmodule

// File: rtl/proppy_bytebeat.sv
// Bytebeat core in the Tiny Tapeout tile pinout: prescaled sample counter,
// registered formula sample, PWM output and tick strobe.
module proppy_bytebeat
    import proppy_bytebeat_pkg::*;
#(
    parameter int T_W = T_W_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic [15:0]    presc_q;
    logic [15:0]    presc_d;
    logic [T_W-1:0] t_q;
    logic [T_W-1:0] t_d;
    logic [7:0]     sample_q;
    logic [7:0]     sample_d;
    logic [7:0]     pc_q;
    logic [7:0]     pc_d;
    logic           tick_q;
    logic           tick_d;

    logic [15:0]    period;
    logic           pause;
    logic           clear;
    logic           tick;
    logic [T_W-1:0] formula_t;
    logic [7:0]     formula_out;
    logic           unused_inputs;

    assign pause         = ui_in[5];
    assign clear         = ui_in[6];
    assign period        = rate_div(ui_in[4:3]);
    assign unused_inputs = ^{ena, uio_in};

    // The >= compare lets a shorter rate take effect without waiting for a wrap.
    always_comb begin
        tick    = !pause && (presc_q >= (period - 16'd1));
        presc_d = presc_q;
        if (!pause) begin
            presc_d = tick ? 16'd0 : presc_q + 16'd1;
        end
    end

    assign formula_t = clear ? '0 : t_q;

    bytebeat_formula #(
        .T_W (T_W)
    ) u_formula (
        .t      (formula_t),
        .sel    (ui_in[2:0]),
        .sample (formula_out)
    );

    // Clear overrides both tick and pause on t; the sample still updates from t=0.
    always_comb begin
        t_d      = t_q;
        sample_d = sample_q;
        tick_d   = tick;
        pc_d     = pc_q + 8'd1;
        if (clear) begin
            t_d = '0;
        end else if (tick) begin
            t_d = t_q + T_W'(1);
        end
        if (tick) begin
            sample_d = formula_out;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q  <= 16'd0;
            t_q      <= '0;
            sample_q <= 8'd0;
            pc_q     <= 8'd0;
            tick_q   <= 1'b0;
        end else begin
            presc_q  <= presc_d;
            t_q      <= t_d;
            sample_q <= sample_d;
            pc_q     <= pc_d;
            tick_q   <= tick_d;
        end
    end

    assign uo_out  = ui_in[7] ? t_q[7:0] : sample_q;
    assign uio_out = {t_q[15:10], tick_q, (pc_q < sample_q)};
    assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_proppy_bytebeat.sv
// Self-checking bench for proppy_bytebeat: a per-cycle reference model
// plus directed scenarios with hand-computed expectations.
module tb_proppy_bytebeat;

    logic       clk;
    logic       rst;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int checks;
    int passed;

    proppy_bytebeat dut (
        .clk     (clk),
        .rst     (rst),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference formulas evaluated with wide integer arithmetic, then reduced mod 256.
    function automatic int unsigned fref(input int sel, input longint unsigned t);
        longint unsigned r;
        case (sel)
            0:       r = t;
            1:       r = t * ((t >> 5) | (t >> 8));
            2:       r = t * (((t >> 12) | (t >> 8)) & 63 & (t >> 4));
            3:       r = ((t * 5) & (t >> 7)) | ((t * 3) & (t >> 10));
            4:       r = t * ((t >> 11) & (t >> 8) & 123 & (t >> 3));
            5:       r = t ^ (t >> 8);
            6:       r = ((t * 9) & (t >> 4)) | ((t * 5) & (t >> 7)) | ((t * 3) & (t >> 10));
            default: r = ((t >> 10) & 42) * t;
        endcase
        return int'(r % 256);
    endfunction

    function automatic int period_of(input logic [1:0] r);
        case (r)
            2'd0:    return 1;
            2'd1:    return 16;
            2'd2:    return 256;
            default: return 1250;
        endcase
    endfunction

    int unsigned m_t;
    int unsigned m_sample;
    int unsigned m_pc;
    int          m_since;
    bit          m_strobe;
    bit          m_tick;

    // Model: m_since counts clocks since the last tick; a tick fires on the Nth clock.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_t      = 0;
            m_sample = 0;
            m_pc     = 0;
            m_since  = 0;
            m_strobe = 1'b0;
        end else begin
            m_tick = 1'b0;
            if (!ui_in[5]) begin
                m_since = m_since + 1;
                if (m_since >= period_of(ui_in[4:3])) begin
                    m_tick  = 1'b1;
                    m_since = 0;
                end
            end
            if (m_tick) m_sample = fref(int'(ui_in[2:0]), ui_in[6] ? 64'd0 : 64'(m_t));
            if (ui_in[6]) m_t = 0;
            else if (m_tick) m_t = (m_t + 1) % (1 << 24);
            m_strobe = m_tick;
            m_pc     = (m_pc + 1) % 256;
        end
    end

    task automatic checkOutput(input string name, input int unsigned actual, input int unsigned expected);
        checks = checks + 1;
        if (actual == expected) begin
            passed = passed + 1;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [7:0] exp_uo;
        logic [7:0] exp_uio;
        logic [31:0] tv;
        tv      = m_t;
        exp_uo  = ui_in[7] ? tv[7:0] : 8'(m_sample);
        exp_uio = {tv[15:10], m_strobe, (m_pc < m_sample)};
        checkOutput("model uo_out", uo_out, exp_uo);
        checkOutput("model uio_out", uio_out, exp_uio);
        checkOutput("uio_oe", uio_oe, 8'hFF);
    end

    task automatic applyStimulus(input logic [7:0] ui, input int cycles);
        #1;
        ui_in = ui;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic resetDut(input logic [7:0] ui);
        @(negedge clk);
        #1;
        rst   = 1'b1;
        ui_in = ui;
        @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    int strobes;
    int changes;
    int highs;
    logic [7:0] prev_uo;

    initial begin
        checks = 0;
        passed = 0;
        rst    = 1'b1;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;

        repeat (2) @(negedge clk);
        checkOutput("reset uo_out", uo_out, 0);
        checkOutput("reset uio_out", uio_out, 0);
        checkOutput("reset uio_oe", uio_oe, 8'hFF);
        #1 rst = 1'b0;

        // Sawtooth ramp, one step per clock, wrapping 255 -> 0.
        applyStimulus(8'h00, 256);
        checkOutput("ramp 255", uo_out, 255);
        checkOutput("ramp strobe", uio_out[1], 1);
        applyStimulus(8'h00, 1);
        checkOutput("ramp wrap", uo_out, 0);

        // Formula 1 after consuming t=300, then the t[7:0] output mux.
        resetDut(8'h01);
        applyStimulus(8'h01, 301);
        checkOutput("f1 t=300", uo_out, 140);
        #1 ui_in = 8'h81;
        #1 checkOutput("mux t[7:0]", uo_out, 45);
        ui_in = 8'h01;

        // Formula 7 at t=2048 and t=2049.
        resetDut(8'h07);
        applyStimulus(8'h07, 2049);
        checkOutput("f7 t=2048", uo_out, 0);
        applyStimulus(8'h07, 1);
        checkOutput("f7 t=2049", uo_out, 2);

        // Other formulas are covered by the per-cycle model.
        for (int s = 2; s <= 6; s++) begin
            resetDut(8'(s));
            applyStimulus(8'(s), 300);
        end

        // Rate 1: one tick every 16 clocks.
        resetDut(8'h08);
        strobes = 0;
        changes = 0;
        prev_uo = uo_out;
        for (int i = 0; i < 64; i++) begin
            applyStimulus(8'h08, 1);
            if (uio_out[1]) strobes++;
            if (uo_out != prev_uo) changes++;
            prev_uo = uo_out;
        end
        checkOutput("rate16 strobes", strobes, 4);
        checkOutput("rate16 changes", changes, 3);
        checkOutput("rate16 value", uo_out, 3);

        // Pause freezes, clear forces t=0, ramp resumes afterwards.
        resetDut(8'h00);
        applyStimulus(8'h00, 100);
        checkOutput("pre-pause", uo_out, 99);
        applyStimulus(8'h20, 50);
        checkOutput("paused sample", uo_out, 99);
        checkOutput("paused strobe", uio_out[1], 0);
        #1 ui_in = 8'hA0;
        #1 checkOutput("paused t", uo_out, 100);
        ui_in = 8'h20;
        applyStimulus(8'h00, 1);
        checkOutput("unpause", uo_out, 100);
        applyStimulus(8'h40, 5);
        checkOutput("clear", uo_out, 0);
        applyStimulus(8'h00, 1);
        checkOutput("clear release", uo_out, 0);
        applyStimulus(8'h00, 1);
        checkOutput("ramp resumes", uo_out, 1);

        // PWM duty with the sample frozen at 64.
        resetDut(8'h00);
        applyStimulus(8'h00, 65);
        checkOutput("pwm sample", uo_out, 64);
        highs = 0;
        for (int i = 0; i < 256; i++) begin
            applyStimulus(8'h20, 1);
            if (uio_out[0]) highs++;
        end
        checkOutput("pwm duty", highs, 64);

        // Asynchronous reset between clock edges.
        resetDut(8'h00);
        applyStimulus(8'h00, 40);
        #2 rst = 1'b1;
        #1;
        checkOutput("async uo_out", uo_out, 0);
        checkOutput("async uio_out", uio_out, 0);
        @(negedge clk);
        #1 rst = 1'b0;
        applyStimulus(8'h00, 3);
        checkOutput("restart", uo_out, 2);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/proppy_bytebeat.md
# proppy_bytebeat

Bytebeat audio generator core for the Tiny Tapeout tile. A prescaled sample counter `t` drives one of eight hard-wired integer formulas, and the block emits the low byte of the selected formula as an 8-bit audio sample. The sample is driven in parallel on `uo_out` and as a PWM bitstream on `uio_out[0]` for an external RC filter. A thin top-level wrapper adapts this core to the standard tile pinout.

## Interface
- `T_W`, default 24: width of sample counter `t`.
- `clk` input 1: single clock, 10 MHz nominal.
- `rst` input 1: reset, asynchronous, active-high.
- `ena` input 1: tile enable; ignored.
- `ui_in` input 8:
  - [2:0] formula select.
  - [4:3] rate select.
  - [5] pause.
  - [6] synchronous clear of `t`.
  - [7] output mux.
- `uio_in` input 8: unused.
- `uo_out` output 8: sample byte, or `t[7:0]` when `ui_in[7]`=1.
- `uio_out` output 8:
  - [0] PWM of the sample.
  - [1] tick strobe.
  - [7:2] `t[15:10]`.
- `uio_oe` output 8: constant 8'hFF.

## Operation
- **Prescaler** (16-bit) sets the tick period N from `ui_in[4:3]`: 0→1, 1→16, 2→256, 3→1250 cycles.
  - `tick` asserts when `prescaler >= N-1`; the prescaler then returns to 0. Otherwise it increments.
  - The `>=` compare makes a rate change safe mid-count.
- **Pause** (`ui_in[5]`=1): prescaler, `t`, and sample all hold. PWM keeps running.
- **Clear** (`ui_in[6]`=1): `t` <= 0 every cycle, with priority over tick. The sample register still updates on tick, using `t`=0.
- **On tick:** `sample <= f_sel(t)[7:0]`, then `t <= t+1`. `t` wraps modulo 2^T_W.
- **Formulas.** All arithmetic is unsigned, shifts are logical, and only the low 8 bits of the result are kept:
  - 0: `t`
  - 1: `t*((t>>5)|(t>>8))`
  - 2: `t*(((t>>12)|(t>>8))&63&(t>>4))`
  - 3: `((t*5)&(t>>7))|((t*3)&(t>>10))`
  - 4: `t*((t>>11)&(t>>8)&123&(t>>3))`
  - 5: `t^(t>>8)`
  - 6: `((t*9)&(t>>4))|((t*5)&(t>>7))|((t*3)&(t>>10))`
  - 7: `((t>>10)&42)*t`
- **Multiplier width.** Because only 8 output bits matter, the multipliers only need 8×8 truncated to 8 bits.
- **Formula select** may change at any time; the new formula takes effect at the next tick.
- **PWM:** a free-running 8-bit counter `pc`, incrementing every clock. `uio_out[0] = (pc < sample)`. Sample 0 gives constant low; sample 255 gives high for 255 of every 256 cycles.
- **Reset values:** `t`, prescaler, sample, `pc` = 0. Hence `uo_out` = 0, `uio_out` = 0, `uio_oe` = 8'hFF.

## Timing
- All state is on the rising edge of `clk`. Reset is asynchronous assert.
- **Release from reset:** the first tick occurs in the first clock cycle after `rst` deasserts when N=1. In general, after N clocks.
- **Latency:** `uo_out` shows `f(t_k)` starting the cycle after the tick that consumed `t_k`. It is registered, so there are no combinational paths from `ui_in[2:0]` to `uo_out`.
- **Output-mux exception:** the `ui_in[7]` mux is combinational and shows the current registered `t[7:0]`.
- **Tick strobe:** `uio_out[1]` is registered and high for exactly one cycle per tick. It is low during pause.
- **Reset mid-operation:** all outputs return to their reset values immediately. The sequence restarts at `t`=0.

## Structure
- **Shared package:** formula-select encoding constants (`F_SAW` … `F_F7`), the rate-divisor table, and `T_W`.
- **Sub-module:** `bytebeat_formula`, purely combinational. Inputs `t` and `sel`; output 8-bit sample.
- **Core:** the prescaler, `t`, sample register, PWM, and output mapping live here.

## Test plan
- **Reset and ramp:** `ui_in`=0, release `rst` → `uo_out` = 0,1,2,… one per clock. 255 is followed by 0. Strobe `uio_out[1]` is high every cycle.
- **Formula value:** formula 1, N=1, run until `t`=300 is consumed → `uo_out`=140. Formula 7 at `t`=2049 → 2; at `t`=2048 → 0.
- **Rate:** `ui_in[4:3]`=1 → `uo_out` changes exactly every 16 clocks. `uio_out[1]` pulses once per 16 clocks.
- **Pause and clear:** assert `ui_in[5]` for 50 clocks → `uo_out` and `t` are frozen. Assert `ui_in[6]` with formula 0 → `uo_out`=0 after the next tick; the ramp resumes from 1 after release.
- **PWM:** hold sample at 64 (formula 0, `t`=64, then pause) → `uio_out[0]` is high for 64 of every 256 clocks.
- **Async reset mid-run:** pulse `rst` between clock edges → `uo_out`=0 and `uio_out`=0 before the next edge.
